// File: rtl/idma_axis_loopback_nch.sv
// ----------------------------------------------------------------------------
// idma_axis_loopback_nch
//
// Multi-channel AXI-Stream loopback for iDMA streaming back-ends. Each channel
// accepts beats from the iDMA write stream into a small FIFO. On the way in it
// optionally transforms the data: pass, invert, or byte-reverse. It returns
// the beats on the matching read stream after a programmable minimum delay.
// Channels share nothing; each has its own FIFO, timer and counters.
//
// Ports
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   flush_i     per-channel synchronous FIFO clear
//   mode_i      per-channel 2-bit transform: 0 pass, 1 invert, 2 byte-reverse,
//               3 pass
//   delay_i     per-channel extra cycles between head visibility and tvalid
//   in_req_i    ingress stream (iDMA streaming write request)
//   in_rsp_o    ingress tready
//   out_req_o   egress stream (iDMA streaming read request)
//   out_rsp_i   egress tready
//   fill_o      per-channel FIFO occupancy, including the beat on egress
//   beat_cnt_o  per-channel egress handshakes, wrapping
//   pkt_cnt_o   per-channel egress handshakes with last set, wrapping
// ----------------------------------------------------------------------------
module idma_axis_loopback_nch #(
  parameter int unsigned NumChannels = 1,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned DelayWidth  = 8,
  parameter int unsigned CntWidth    = 32,
  parameter type axis_req_t = struct packed {
    struct packed {
      logic [DataWidth-1:0]   data;
      logic [DataWidth/8-1:0] strb;
      logic [DataWidth/8-1:0] keep;
      logic                   last;
      logic [3:0]             id;
      logic [3:0]             dest;
      logic [0:0]             user;
    } t;
    logic tvalid;
  },
  parameter type axis_rsp_t = struct packed {
    logic tready;
  },
  localparam int unsigned FillWidth = $clog2(FifoDepth) + 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumChannels-1:0]            flush_i,
  input  logic [2*NumChannels-1:0]          mode_i,
  input  logic [DelayWidth*NumChannels-1:0] delay_i,
  input  axis_req_t [NumChannels-1:0]       in_req_i,
  output axis_rsp_t [NumChannels-1:0]       in_rsp_o,
  output axis_req_t [NumChannels-1:0]       out_req_o,
  input  axis_rsp_t [NumChannels-1:0]       out_rsp_i,
  output logic [FillWidth*NumChannels-1:0]  fill_o,
  output logic [CntWidth*NumChannels-1:0]   beat_cnt_o,
  output logic [CntWidth*NumChannels-1:0]   pkt_cnt_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned PtrWidth = $clog2(FifoDepth);

  // Transform applied on ingress so the stored beat is already final.
  function automatic axis_req_t xform(input axis_req_t r, input logic [1:0] m);
    axis_req_t o;
    o = r;
    case (m)
      2'd1: o.t.data = ~r.t.data;
      2'd2: begin
        for (int i = 0; i < NumBytes; i++) begin
          o.t.data[8*i +: 8] = r.t.data[8*(NumBytes-1-i) +: 8];
          o.t.strb[i]        = r.t.strb[NumBytes-1-i];
          o.t.keep[i]        = r.t.keep[NumBytes-1-i];
        end
      end
      default: ;
    endcase
    return o;
  endfunction

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    axis_req_t             mem [FifoDepth];
    axis_req_t             head_q;
    axis_req_t             o_req;
    axis_rsp_t             o_rsp;
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FillWidth-1:0]  fill_q, fill_nxt;
    logic [DelayWidth-1:0] tmr_q;
    logic [CntWidth-1:0]   beat_q, pkt_q;
    logic                  rdy_q, vis_q;
    logic                  out_vld, push, pop, load;

    assign out_vld = vis_q && (tmr_q == '0);
    assign push    = in_req_i[c].tvalid && rdy_q && !flush_i[c];
    assign pop     = out_vld && out_rsp_i[c].tready;
    // fill counts the visible head too, so beats still waiting in storage
    // are fill - vis_q. A beat written at this edge is not yet counted, which
    // prevents fall-through.
    assign load     = (!vis_q || pop) && ((fill_q - FillWidth'(vis_q)) != '0);
    assign fill_nxt = fill_q + FillWidth'(push) - FillWidth'(pop);

    always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= xform(in_req_i[c], mode_i[2*c +: 2]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        fill_q   <= '0;
        tmr_q    <= '0;
        vis_q    <= 1'b0;
        rdy_q    <= 1'b0;
      end else if (flush_i[c]) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        fill_q   <= '0;
        tmr_q    <= '0;
        vis_q    <= 1'b0;
        rdy_q    <= 1'b1;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
        if (load) rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
        fill_q <= fill_nxt;
        // Ready looks at the registered fill only; a pop this cycle does not
        // open a slot until the next one.
        rdy_q  <= (fill_nxt < FillWidth'(FifoDepth));
        if (load) begin
          vis_q <= 1'b1;
          tmr_q <= delay_i[DelayWidth*c +: DelayWidth];
        end else if (pop) begin
          vis_q <= 1'b0;
        end else if (vis_q && (tmr_q != '0)) begin
          tmr_q <= tmr_q - DelayWidth'(1);
        end
      end
    end

    // Egress register: holds t.* stable while tvalid waits for tready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   head_q <= '0;
      else if (load && !flush_i[c]) head_q <= mem[rd_ptr_q];
    end

    // Counters see the handshake even in a flush cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        beat_q <= '0;
        pkt_q  <= '0;
      end else if (pop) begin
        beat_q <= beat_q + CntWidth'(1);
        if (head_q.t.last) pkt_q <= pkt_q + CntWidth'(1);
      end
    end

    always_comb begin
      o_req        = head_q;
      o_req.tvalid = out_vld;
      o_rsp        = '0;
      o_rsp.tready = rdy_q && !flush_i[c];
    end

    assign out_req_o[c]                            = o_req;
    assign in_rsp_o[c]                             = o_rsp;
    assign fill_o[FillWidth*c +: FillWidth]        = fill_q;
    assign beat_cnt_o[CntWidth*c +: CntWidth]      = beat_q;
    assign pkt_cnt_o[CntWidth*c +: CntWidth]       = pkt_q;
  end

endmodule

// File: tb/tb_idma_axis_loopback_nch.sv
// ----------------------------------------------------------------------------
// tb_idma_axis_loopback_nch
//
// Two-channel bench for idma_axis_loopback_nch. The stimulus pushes each
// expected egress beat into a scoreboard queue when it issues the beat. A
// forked monitor pops that queue and compares the beat on every egress
// handshake. Timing, counters, flush and reset are checked inline.
// ----------------------------------------------------------------------------
module tb_idma_axis_loopback_nch;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [0:0]  user;
  } tb_t_t;
  typedef struct packed { tb_t_t t; logic tvalid; } tb_req_t;
  typedef struct packed { logic tready; } tb_rsp_t;

  typedef struct { int ch; logic [63:0] data; logic [7:0] strb; logic last; } exp_t;
  typedef struct { int ch; int cyc; } pop_t;

  logic              clk, rst_n;
  logic [1:0]        flush;
  logic [3:0]        mode;
  logic [15:0]       delay;
  tb_req_t [1:0]     in_req, out_req;
  tb_rsp_t [1:0]     in_rsp, out_rsp;
  logic [5:0]        fill;
  logic [63:0]       beat_cnt, pkt_cnt;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  pop_t pop_log[$];

  idma_axis_loopback_nch #(
    .NumChannels(2), .DataWidth(64), .FifoDepth(4), .DelayWidth(8), .CntWidth(32),
    .axis_req_t(tb_req_t), .axis_rsp_t(tb_rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .mode_i(mode), .delay_i(delay),
    .in_req_i(in_req), .in_rsp_o(in_rsp), .out_req_o(out_req), .out_rsp_i(out_rsp),
    .fill_o(fill), .beat_cnt_o(beat_cnt), .pkt_cnt_o(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic bit pending(input int c);
    foreach (exp_q[i]) if (exp_q[i].ch == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int c = 0; c < 2; c++) begin
          if (out_req[c].tvalid && out_rsp[c].tready) begin
            int   idx;
            exp_t e;
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
              if (exp_q[i].ch == c) begin idx = i; break; end
            end
            pop_log.push_back('{c, cyc});
            if (idx < 0) begin
              n_cmp++; n_err++;
              $display("FAIL unexpected_egress ch%0d: got data %h, required no beat", c, out_req[c].t.data);
            end else begin
              e = exp_q[idx];
              exp_q.delete(idx);
              chk($sformatf("egress_data ch%0d", c), out_req[c].t.data, e.data);
              chk($sformatf("egress_strb_keep_last ch%0d", c),
                  {out_req[c].t.strb, out_req[c].t.keep, out_req[c].t.last},
                  {e.strb, 8'hFF, e.last});
            end
          end
        end
      end
    end
  endtask

  // Drive one beat and return the edge index at which it was accepted.
  task automatic push(input int c, input logic [63:0] d, input logic [7:0] s, input logic l,
                      input logic [1:0] m, input logic [63:0] ed, input logic [7:0] es,
                      output int k);
    int n;
    exp_q.push_back('{c, ed, es, l});
    mode[2*c +: 2]     = m;
    in_req[c].t.data   = d;
    in_req[c].t.strb   = s;
    in_req[c].t.keep   = 8'hFF;
    in_req[c].t.last   = l;
    in_req[c].tvalid   = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_rsp[c].tready) break;
    end
    if (n == 200) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout ch%0d: got tready 0, required 1", c);
    end
    @(posedge clk); #1;
    k = cyc;
    in_req[c].tvalid = 1'b0;
  endtask

  task automatic drain(input int c);
    int n;
    for (n = 0; n < 300; n++) begin
      if (!pending(c)) break;
      @(negedge clk);
    end
    if (n == 300) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout ch%0d: got beats pending, required none", c);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic int pops_of(input int c, input int idx);
    int n;
    n = 0;
    foreach (pop_log[i]) begin
      if (pop_log[i].ch == c) begin
        if (n == idx) return pop_log[i].cyc;
        n++;
      end
    end
    return -1;
  endfunction

  initial begin
    int k, k0, b0;
    rst_n = 1'b0;
    flush = '0; mode = '0; delay = '0; in_req = '0; out_rsp = '0;
    out_rsp[0].tready = 1'b1;
    out_rsp[1].tready = 1'b1;
    fork monitor(); join_none
    fork begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
    end join_none

    // Reset state
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("rst_in_tready ch%0d", c), in_rsp[c].tready, 0);
      chk($sformatf("rst_out_tvalid ch%0d", c), out_req[c].tvalid, 0);
      chk($sformatf("rst_fill ch%0d", c), fill[3*c +: 3], 0);
      chk($sformatf("rst_beat_cnt ch%0d", c), beat_cnt[32*c +: 32], 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single beat, delay 0 -> valid in the cycle after the push edge
    pop_log.delete();
    push(0, 64'hA5A5_0001, 8'hFF, 1'b1, 2'd0, 64'hA5A5_0001, 8'hFF, k);
    drain(0);
    chk("t1_valid_cycle", pops_of(0, 0), k + 1);
    chk("t1_beat_cnt", beat_cnt[31:0], 1);
    chk("t1_pkt_cnt", pkt_cnt[31:0], 1);

    // 2: delay 3, 8-beat packet -> beats 4 cycles apart
    delay[7:0] = 8'd3;
    pop_log.delete();
    for (int i = 0; i < 8; i++) begin
      push(0, 64'h1000 + 64'(i), 8'hFF, (i == 7), 2'd0, 64'h1000 + 64'(i), 8'hFF, k);
      if (i == 0) k0 = k;
    end
    drain(0);
    chk("t2_first_valid", pops_of(0, 0), k0 + 4);
    for (int i = 1; i < 8; i++)
      chk($sformatf("t2_spacing beat%0d", i), pops_of(0, i) - pops_of(0, i - 1), 4);
    chk("t2_pkt_cnt", pkt_cnt[31:0], 2);
    chk("t2_beat_cnt", beat_cnt[31:0], 9);

    // 3: egress stalled, FIFO fills at 4 and ingress stops
    delay[7:0] = 8'd0;
    out_rsp[0].tready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(0, 64'h3000 + 64'(i), 8'hFF, 1'b0, 2'd0, 64'h3000 + 64'(i), 8'hFF, k);
    @(negedge clk);
    chk("t3_tready_full", in_rsp[0].tready, 0);
    chk("t3_fill_full", fill[2:0], 4);
    @(posedge clk); #1;
    out_rsp[0].tready = 1'b1;
    push(0, 64'h3004, 8'hFF, 1'b0, 2'd0, 64'h3004, 8'hFF, k);
    push(0, 64'h3005, 8'hFF, 1'b1, 2'd0, 64'h3005, 8'hFF, k);
    drain(0);
    chk("t3_beat_cnt", beat_cnt[31:0], 15);
    chk("t3_pkt_cnt", pkt_cnt[31:0], 3);

    // 4: transforms on channel 1
    push(1, 64'h0102_0304_0506_0708, 8'h0F, 1'b1, 2'd2, 64'h0807_0605_0403_0201, 8'hF0, k);
    push(1, 64'h0, 8'hFF, 1'b1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, k);
    push(1, 64'hDEAD_BEEF_0123_4567, 8'h3C, 1'b1, 2'd3, 64'hDEAD_BEEF_0123_4567, 8'h3C, k);
    drain(1);
    chk("t4_beat_cnt ch1", beat_cnt[63:32], 3);

    // 5: ch0 stalled does not slow ch1
    out_rsp[0].tready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(0, 64'h5000 + 64'(i), 8'hFF, (i == 2), 2'd0, 64'h5000 + 64'(i), 8'hFF, k);
    pop_log.delete();
    for (int i = 0; i < 6; i++)
      push(1, 64'h6000 + 64'(i), 8'hFF, (i == 5), 2'd0, 64'h6000 + 64'(i), 8'hFF, k);
    drain(1);
    for (int i = 1; i < 6; i++)
      chk($sformatf("t5_ch1_spacing beat%0d", i), pops_of(1, i) - pops_of(1, i - 1), 1);
    chk("t5_ch0_fill_held", fill[2:0], 3);
    out_rsp[0].tready = 1'b1;
    drain(0);
    chk("t5_pkt_cnt ch0", pkt_cnt[31:0], 4);
    chk("t5_pkt_cnt ch1", pkt_cnt[63:32], 4);

    // 6: flush with 3 queued and a handshake in the same cycle
    out_rsp[0].tready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(0, 64'h7000 + 64'(i), 8'hFF, 1'b0, 2'd0, 64'h7000 + 64'(i), 8'hFF, k);
    @(posedge clk); #1;
    b0 = int'(beat_cnt[31:0]);
    flush[0] = 1'b1;
    out_rsp[0].tready = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].ch == 0) exp_q.delete(i);
    chk("t6_fill_after_flush", fill[2:0], 0);
    chk("t6_tvalid_after_flush", out_req[0].tvalid, 0);
    chk("t6_beat_cnt_counted", beat_cnt[31:0], b0 + 1);
    pop_log.delete();
    repeat (6) @(posedge clk); #1;
    chk("t6_no_egress_after_flush", pop_log.size(), 0);
    chk("t6_beat_cnt_total", beat_cnt[31:0], 19);

    // Mid-packet asynchronous reset
    out_rsp[1].tready = 1'b0;
    push(1, 64'h8000, 8'hFF, 1'b0, 2'd0, 64'h8000, 8'hFF, k);
    push(1, 64'h8001, 8'hFF, 1'b0, 2'd0, 64'h8001, 8'hFF, k);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("arst_out_tvalid ch%0d", c), out_req[c].tvalid, 0);
      chk($sformatf("arst_out_data ch%0d", c), out_req[c].t.data, 0);
      chk($sformatf("arst_in_tready ch%0d", c), in_rsp[c].tready, 0);
      chk($sformatf("arst_fill ch%0d", c), fill[3*c +: 3], 0);
      chk($sformatf("arst_beat_cnt ch%0d", c), beat_cnt[32*c +: 32], 0);
      chk($sformatf("arst_pkt_cnt ch%0d", c), pkt_cnt[32*c +: 32], 0);
    end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_rsp[1].tready = 1'b1;
    push(1, 64'h9999, 8'hFF, 1'b1, 2'd0, 64'h9999, 8'hFF, k);
    drain(1);
    chk("post_rst_beat_cnt ch1", beat_cnt[63:32], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
